// File: rtl/rf_burst_master.sv
// rf_burst_master: initiator for the 8x32 register-file port.
// Accepts burst read/write commands over valid/ready, serialises words onto the
// RF write/read ports with address wrap-around and streams read data back
// through a stallable output register.
// Optional feature macro: RF_CLEAR_EN (op 10 issues a one-cycle rf_clear pulse).
module rf_burst_master #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    // command channel
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    // write-data channel
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    // read-data channel
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    // register-file port
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic          rf_clear,
    // status
    output logic          busy
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          rf_clear_q, rf_clear_d;

    logic          rd_hold;
    logic          rd_take;
    logic          cmd_fire;

    // Consumer is stalling the output register; new commands must wait.
    assign rd_hold   = rd_valid_q && !rd_ready;
    assign rd_take   = rd_valid_q && rd_ready;
    assign cmd_ready = (state_q == ST_IDLE) && !rd_hold;
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign wd_ready  = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);

    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign rd_data   = rd_data_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign rf_raddr  = addr_q;
    assign rf_clear  = rf_clear_q;

    // Next-state and next-register logic for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q && !rd_take;
        rd_last_d  = rd_last_q && !rd_take;
        rd_data_d  = rd_data_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_clear_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    addr_d = cmd_addr;
                    cnt_d  = cmd_len;
                    case (cmd_op)
                        OP_READ:  state_d = ST_READ;
                        OP_WRITE: state_d = ST_WRITE;
                        OP_CLEAR: begin
`ifdef RF_CLEAR_EN
                            state_d    = ST_CLEAR;
                            rf_clear_d = 1'b1;
`endif
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            ST_WRITE: begin
                if (wd_valid) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = addr_q;
                    rf_wdata_d = wd_data;
                    addr_d     = addr_q + AW'(1);
                    cnt_d      = cnt_q - AW'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_READ: begin
                if (!rd_valid_q || rd_ready) begin
                    rd_data_d  = rf_rdata;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (cnt_q == '0);
                    addr_d     = addr_q + AW'(1);
                    cnt_d      = cnt_q - AW'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_CLEAR: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_clear_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_clear_q <= rf_clear_d;
        end
    end

endmodule

// File: tb/tb_rf_burst_master.sv
// Testbench for rf_burst_master: directed bursts against a command-level
// memory model and read/write scoreboards, plus literal spot checks.
module tb_rf_burst_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          wd_valid = 1'b0;
    logic          wd_ready;
    logic [DW-1:0] wd_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          rf_clear;
    logic          busy;

    rf_burst_master #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_clear(rf_clear),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file attached to the DUT: combinational read, write at clock edge.
    logic [DW-1:0] rf_mem [8];
    logic          mem_inited = 1'b0;
    assign rf_rdata = rf_mem[rf_raddr];
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 32'hDEAD_0000 + 32'(i);
            mem_inited <= 1'b1;
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } rd_exp_t;

    // Command-level model state.
    logic [DW-1:0] ref_mem [8];
    rd_exp_t       exp_rd[$];
    logic [AW-1:0] exp_waddr[$];
    logic [DW-1:0] exp_wdata[$];
    logic [DW-1:0] cap_data[$];
    logic          cap_last[$];
    int            cap_cyc[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int we_count = 0;
    int rd_mode = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Read-consumer readiness pattern: 0 always ready, 1 alternating, 2 never.
    always @(posedge clk) begin
        #1;
        case (rd_mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = ~rd_ready;
            default: rd_ready = 1'b0;
        endcase
    end

    // Per-cycle compare against the scoreboards.
    always @(negedge clk) begin
        rd_exp_t e;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (rd_valid) begin
                if (prev_stall) check("rd_hold_data", rd_data, prev_data);
                if (rd_ready) begin
                    if (exp_rd.size() == 0) begin
                        check("rd_extra_word", 32'(rd_data), 32'hFFFF_FFFF ^ rd_data);
                    end else begin
                        e = exp_rd.pop_front();
                        check("rd_data", rd_data, e.data);
                        check("rd_last", 32'(rd_last), 32'(e.last));
                        cap_data.push_back(rd_data);
                        cap_last.push_back(rd_last);
                        cap_cyc.push_back(cyc);
                    end
                end
            end else if (prev_stall) begin
                check("rd_valid_hold", 32'(rd_valid), 32'd1);
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (rf_we) begin
                we_count++;
                if (exp_waddr.size() == 0) begin
                    check("rf_we_extra", 32'(rf_we), 32'd0);
                end else begin
                    check("rf_waddr", 32'(rf_waddr), 32'(exp_waddr.pop_front()));
                    check("rf_wdata", rf_wdata, exp_wdata.pop_front());
                end
            end
`ifndef RF_CLEAR_EN
            check("rf_clear_tied", 32'(rf_clear), 32'd0);
`endif
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] l);
        bit ok = 1'b0;
        int n = 0;
        rd_exp_t e;
        cmd_op = op; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            n++;
        end
        #1 cmd_valid = 1'b0;
        if (!ok) begin
            check("cmd_accept_timeout", 32'(ok), 32'd1);
        end else if (op == 2'b00) begin
            for (int i = 0; i <= int'(l); i++) begin
                e.data = ref_mem[AW'(int'(a) + i)];
                e.last = (i == int'(l));
                exp_rd.push_back(e);
            end
        end
    endtask

    task automatic send_words(input logic [AW-1:0] a, input int n, input logic [DW-1:0] base, input int gap);
        for (int i = 0; i < n; i++) begin
            bit ok = 1'b0;
            int k = 0;
            wd_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            wd_valid = 1'b1;
            wd_data  = base + 32'(i);
            while (!ok && k < 200) begin
                @(negedge clk);
                ok = wd_ready;
                @(posedge clk);
                k++;
            end
            #1;
            if (!ok) begin
                check("wd_accept_timeout", 32'(ok), 32'd1);
            end else begin
                exp_waddr.push_back(AW'(int'(a) + i));
                exp_wdata.push_back(base + 32'(i));
                ref_mem[AW'(int'(a) + i)] = base + 32'(i);
            end
        end
        wd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 300 && (busy || rd_valid || exp_rd.size() != 0 || exp_waddr.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        check("drain_rd_left", 32'(exp_rd.size()), 32'd0);
        check("drain_w_left", 32'(exp_waddr.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_wd_ready"}, 32'(wd_ready), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'd0);
        check({tag, "_rd_last"}, 32'(rd_last), 32'd0);
        check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
        check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
        check({tag, "_rf_raddr"}, 32'(rf_raddr), 32'd0);
        check({tag, "_rf_clear"}, 32'(rf_clear), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic clear_caps();
        cap_data.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    initial begin
        int we_start;
        for (int i = 0; i < 8; i++) ref_mem[i] = 32'hDEAD_0000 + 32'(i);

        // Reset state
        #12;
        check_reset_outputs("rst");
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Wrapping write: addr 6, 4 words -> regs 6,7,0,1
        clear_caps();
        we_start = we_count;
        send_cmd(2'b01, 3'd6, 3'd3);
        send_words(3'd6, 4, 32'h0000_00A0, 0);
        wait_done();
        check("wr_reg6", rf_mem[6], 32'h0000_00A0);
        check("wr_reg7", rf_mem[7], 32'h0000_00A1);
        check("wr_reg0", rf_mem[0], 32'h0000_00A2);
        check("wr_reg1", rf_mem[1], 32'h0000_00A3);
        check("wr_reg2_untouched", rf_mem[2], 32'hDEAD_0002);
        check("wr_pulses", 32'(we_count - we_start), 32'd4);
        check("model_reg0", ref_mem[0], 32'h0000_00A2);

        // Full-throughput read of the same burst
        rd_mode = 0;
        clear_caps();
        send_cmd(2'b00, 3'd6, 3'd3);
        wait_done();
        check("rd4_count", 32'(cap_data.size()), 32'd4);
        if (cap_data.size() == 4) begin
            check("rd4_w0", cap_data[0], 32'h0000_00A0);
            check("rd4_w1", cap_data[1], 32'h0000_00A1);
            check("rd4_w2", cap_data[2], 32'h0000_00A2);
            check("rd4_w3", cap_data[3], 32'h0000_00A3);
            check("rd4_last2", 32'(cap_last[2]), 32'd0);
            check("rd4_last3", 32'(cap_last[3]), 32'd1);
            check("rd4_consecutive", 32'(cap_cyc[3] - cap_cyc[0]), 32'd3);
        end

        // 8-word read with stalling consumer, wrapping from 6
        rd_mode = 1;
        clear_caps();
        send_cmd(2'b00, 3'd6, 3'd7);
        wait_done();
        rd_mode = 0;
        check("rd8_count", 32'(cap_data.size()), 32'd8);
        if (cap_data.size() == 8) begin
            check("rd8_w2", cap_data[2], 32'h0000_00A2);
            check("rd8_w7", cap_data[7], 32'hDEAD_0005);
            check("rd8_last7", 32'(cap_last[7]), 32'd1);
        end

        // Gappy write then back-to-back read of the same words
        clear_caps();
        send_cmd(2'b01, 3'd2, 3'd2);
        send_words(3'd2, 3, 32'h0000_00B0, 2);
        send_cmd(2'b00, 3'd2, 3'd2);
        wait_done();
        check("b2b_count", 32'(cap_data.size()), 32'd3);
        if (cap_data.size() == 3) begin
            check("b2b_w0", cap_data[0], 32'h0000_00B0);
            check("b2b_w1", cap_data[1], 32'h0000_00B1);
            check("b2b_w2", cap_data[2], 32'h0000_00B2);
        end

        // Clear op and reserved op
        send_cmd(2'b10, 3'd0, 3'd0);
        @(negedge clk);
`ifdef RF_CLEAR_EN
        check("clr_pulse", 32'(rf_clear), 32'd1);
        check("clr_busy", 32'(busy), 32'd1);
        @(negedge clk);
`endif
        check("clr_done_pulse", 32'(rf_clear), 32'd0);
        check("clr_done_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        send_cmd(2'b11, 3'd0, 3'd0);
        @(negedge clk);
        check("rsv_busy", 32'(busy), 32'd0);
        check("rsv_no_write", 32'(rf_we), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a stalled read burst
        rd_mode = 2;
        send_cmd(2'b00, 3'd0, 3'd7);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_rd_valid", 32'(rd_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_rd.delete();
        rd_mode = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Recovery after reset
        clear_caps();
        send_cmd(2'b00, 3'd6, 3'd0);
        wait_done();
        check("post_rst_count", 32'(cap_data.size()), 32'd1);
        if (cap_data.size() == 1) begin
            check("post_rst_w0", cap_data[0], 32'h0000_00A0);
            check("post_rst_last", 32'(cap_last[0]), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
